int_pending_ctrl: RTL and testbench
===================================

// Module: int_pending_ctrl
// PURPOSE
//  Upstream stage of the vectored interrupt controller. Turns raw accelerator "done" signals into
//  sticky, maskable pending bits and runs the int_req/int_ack handshake with the CPU. Drives
//  done_o[3:0] straight into the vectored controller's done1..done4 inputs, held stable while int_ack is high.
// PARAMETERS
//  NUM_SRC      4  number of interrupt sources; index NUM_SRC-1 has the highest priority (=done4)
//  SYNC_STAGES  2  synchroniser flops per irq_in bit, >=2
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  irq_in       in   NUM_SRC  raw done level/pulse per source, asynchronous to clk
//  mask_we      in   1        write strobe for enable mask
//  mask_wdata   in   NUM_SRC  new enable mask (1=enabled)
//  int_ack      in   1        CPU acknowledge, level; high for >=1 cycle per serviced interrupt
//  int_req      out  1        interrupt request to CPU
//  done_o       out  NUM_SRC  to vectored controller done1..done4
//  pending_o    out  NUM_SRC  raw pending bits, unmasked (status)
//  mask_o       out  NUM_SRC  current enable mask
//  spurious_o   out  1        sticky: int_ack seen in IDLE; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync deassert use): pending=0, mask=0, sync/edge flops=0, state=IDLE,
//   sel=0, int_req=0, done_o=0, spurious_o=0. Reset mid-handshake aborts it; nothing is serviced.
//  Edge capture: per bit, SYNC_STAGES flops then one history flop; rise = sync & ~hist.
//   Rising edge sets pending[i] regardless of mask. Latency: irq_in high at sample edge E0 ->
//   pending_o high after edge E0+SYNC_STAGES; int_req high one edge later (if enabled, IDLE).
//  Mask: mask_we loads mask_wdata on the clock edge; effect visible next cycle. active = pending & mask.
//  FSM (state registered, int_req = (state==REQ)||(state==ACK)):
//   IDLE: |active -> REQ. int_ack high here -> set spurious_o, stay IDLE.
//   REQ : done_o = active. int_ack high -> ACK; on that edge sel <= one-hot of highest set bit
//         of active. active becomes 0 (mask write) before ack -> IDLE, int_req drops next cycle.
//   ACK : done_o = sel (frozen; later edges/mask writes do not change it). int_ack low ->
//         clear pending bit in sel, sel <= 0, -> IDLE. int_req stays high throughout ACK.
//   Back-to-back: after ACK->IDLE, remaining active bits raise int_req again one cycle later
//   (int_req low for exactly one cycle between handshakes).
//  Simultaneous events: rise on bit i in the same cycle its clear fires -> set wins, bit stays pending.
//   Edges on any bit during REQ/ACK are recorded into pending. Mask write and FSM transition in the
//   same cycle: transition decision uses the old mask.
//  Pending is not counted: multiple edges before service collapse to one interrupt.
//  done_o in IDLE = 0. All outputs are registered or decoded from registers only (no comb path
//   from int_ack to int_req).
// STRUCTURE
//  Package int_pkg: NUM_SRC_DEF=4, SYNC_STAGES_DEF=2, typedef enum {IDLE,REQ,ACK} int_state_t,
//   function prio_onehot(vec) (highest-index-wins, same table as vectored controller).
//  Sub-module sync_edge_detect #(WIDTH,SYNC_STAGES): clk, rst_n, d -> rise (one-cycle pulse).
//  Top holds mask/pending registers, FSM, sel register, output muxing.
// TESTING
//  1 Reset: rst_n=0 mid-ACK with pending=4'b0110 -> all outputs 0 immediately, state IDLE after release.
//  2 Single: mask=4'b1111, irq_in[1] rises -> pending_o=4'b0010 after 2 edges, int_req 1 edge later,
//    done_o=4'b0010; ack high 3 cycles then low -> pending_o=0, int_req=0 next cycle.
//  3 Priority: irq_in=4'b0101 same cycle -> ack: done_o=4'b0100 frozen; irq_in[3] rises during ACK,
//    done_o unchanged; after release int_req low 1 cycle, then done_o=4'b1001, next ack selects 4'b1000.
//  4 Masking: mask=4'b0001, irq_in[2] rises -> pending_o=4'b0100, int_req=0; write mask=4'b0100
//    -> int_req high 1 cycle after write; write mask=0 in REQ before ack -> int_req drops, pending kept.
//  5 Collision: irq_in[0] re-rises so rise arrives on the clear edge -> pending_o[0] stays 1, new req.
//  6 Spurious: int_ack pulse with pending=0 -> spurious_o=1, int_req=0, done_o=0, stays set until reset.

Source files
------------

// File: rtl/int_pending_ctrl_pkg.sv
// Shared types and helpers for the interrupt pending controller.
// Priority rule matches the downstream vectored controller: highest index wins.
package int_pkg;

  localparam int unsigned NUM_SRC_DEF     = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned PRIO_W          = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } int_state_t;

  // One-hot of the highest set bit; callers zero-extend narrower vectors.
  function automatic logic [PRIO_W-1:0] prio_onehot(input logic [PRIO_W-1:0] vec);
    logic [PRIO_W-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < int'(PRIO_W); i++) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/int_pending_ctrl_if.sv
// Source/CPU-side signal bundle of the interrupt pending controller.
// master = environment driving sources and ack, slave = the controller.
interface int_pending_ctrl_if #(
  parameter int unsigned NUM_SRC = int_pkg::NUM_SRC_DEF
) ();

  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               int_ack;
  logic               int_req;
  logic [NUM_SRC-1:0] done_o;
  logic [NUM_SRC-1:0] pending_o;
  logic [NUM_SRC-1:0] mask_o;
  logic               spurious_o;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack,
    input  int_req, done_o, pending_o, mask_o, spurious_o
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack,
    output int_req, done_o, pending_o, mask_o, spurious_o
  );

endinterface

// File: rtl/int_pending_ctrl_sync_edge_detect.sv
// Multi-flop synchroniser per bit followed by a history flop; emits a
// one-cycle rise pulse for each synchronised 0->1 transition.
module sync_edge_detect #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/int_pending_ctrl.sv
// Upstream stage of the vectored interrupt controller: sticky maskable pending
// bits plus the int_req/int_ack handshake that feeds done_o to the vectored stage.
module int_pending_ctrl
  import int_pkg::*;
#(
  parameter int unsigned NUM_SRC     = NUM_SRC_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  int_pending_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] sel_q;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] done_sel;
  logic               spurious_q;
  int_state_t         state_q;

  sync_edge_detect #(
    .WIDTH       (NUM_SRC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.irq_in),
    .rise  (rise)
  );

  assign active = pending_q & mask_q;
  assign clr    = (state_q == ACK && !bus.int_ack) ? sel_q : '0;

  // Pending bits: a new rise outranks a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
      if (bus.mask_we) begin
        mask_q <= bus.mask_wdata;
      end
    end
  end

  // Handshake FSM; decisions see the mask as it was before any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.int_ack) begin
            spurious_q <= 1'b1;
          end else if (|active) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!(|active)) begin
            state_q <= IDLE;
          end else if (bus.int_ack) begin
            state_q <= ACK;
            sel_q   <= NUM_SRC'(prio_onehot(PRIO_W'(active)));
          end
        end
        ACK: begin
          if (!bus.int_ack) begin
            state_q <= IDLE;
            sel_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
        end
      endcase
    end
  end

  // done_o is decoded purely from registers so it is glitch-free toward the vectored stage.
  always_comb begin
    done_sel = '0;
    case (state_q)
      REQ:     done_sel = active;
      ACK:     done_sel = sel_q;
      default: done_sel = '0;
    endcase
  end

  assign bus.int_req    = (state_q == REQ) || (state_q == ACK);
  assign bus.done_o     = done_sel;
  assign bus.pending_o  = pending_q;
  assign bus.mask_o     = mask_q;
  assign bus.spurious_o = spurious_q;

endmodule

// File: tb/tb_int_pending_ctrl.sv
// Self-checking bench for int_pending_ctrl: per-cycle vector table with a
// scoreboard of expected output words, plus a hand-written async reset sequence.
module tb_int_pending_ctrl;

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       spur;
    logic       req;
    logic [3:0] done;
    logic [3:0] pend;
    logic [3:0] mask;
  } vec_t;

  typedef struct {
    string       name;
    logic [13:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  int_pending_ctrl_if #(.NUM_SRC(4)) bus ();

  int_pending_ctrl #(
    .NUM_SRC     (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                              input logic ack, input logic spur, input logic req,
                              input logic [3:0] done, input logic [3:0] pend,
                              input logic [3:0] mask);
    vec_t v;
    v.irq = irq; v.we = we; v.wd = wd; v.ack = ack;
    v.spur = spur; v.req = req; v.done = done; v.pend = pend; v.mask = mask;
    return v;
  endfunction

  function automatic logic [13:0] pack(input logic spur, input logic req, input logic [3:0] done,
                                       input logic [3:0] pend, input logic [3:0] mask);
    return {spur, req, done, pend, mask};
  endfunction

  task automatic expect_out(input string name, input logic [13:0] e);
    sb_t s;
    s.name = name;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic check_out();
    sb_t         s;
    logic [13:0] act;
    act = {bus.spurious_o, bus.int_req, bus.done_o, bus.pending_o, bus.mask_o};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: output %h observed with no expectation queued", act);
    end else begin
      s = sb_q.pop_front();
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s: got spur=%b req=%b done=%b pend=%b mask=%b, expected spur=%b req=%b done=%b pend=%b mask=%b",
                 s.name, act[13], act[12], act[11:8], act[7:4], act[3:0],
                 s.exp[13], s.exp[12], s.exp[11:8], s.exp[7:4], s.exp[3:0]);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bus.irq_in     = v.irq;
    bus.mask_we    = v.we;
    bus.mask_wdata = v.wd;
    bus.int_ack    = v.ack;
    expect_out(name, pack(v.spur, v.req, v.done, v.pend, v.mask));
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.irq_in     = '0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    bus.int_ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", 14'd0);
    check_out();
    rst_n = 1'b1;

    //            irq     we  wd      ack  spur req done    pend    mask
    // single source, 3-cycle ack
    vecs.push_back(mk(4'b0000,1'b1,4'b1111,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0010,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0010,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0010,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0010,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b1,4'b0010,4'b0010,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0010,4'b0010,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0010,4'b0010,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0010,4'b0010,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    // priority, frozen done_o, back-to-back
    vecs.push_back(mk(4'b0101,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0101,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0101,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b1,4'b0101,4'b0101,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0100,4'b0101,4'b1111));
    vecs.push_back(mk(4'b1000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0100,4'b0101,4'b1111));
    vecs.push_back(mk(4'b1000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0100,4'b0101,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0100,4'b1101,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b1001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b1,4'b1001,4'b1001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b1000,4'b1001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b0,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111));
    // masking: capture while disabled, enable, disable in REQ
    vecs.push_back(mk(4'b0000,1'b1,4'b0001,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b0001));
    vecs.push_back(mk(4'b0100,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b0001));
    vecs.push_back(mk(4'b0100,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b0001));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0100,4'b0001));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0100,4'b0001));
    vecs.push_back(mk(4'b0000,1'b1,4'b0100,1'b0, 1'b0,1'b0,4'b0000,4'b0100,4'b0100));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b1,4'b0100,4'b0100,4'b0100));
    vecs.push_back(mk(4'b0000,1'b1,4'b0000,1'b0, 1'b0,1'b1,4'b0000,4'b0100,4'b0000));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0100,4'b0000));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0100,4'b0000));
    // spurious ack in IDLE, then drain the held pending bit
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b1,1'b0,4'b0000,4'b0100,4'b0000));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0100,4'b0000));
    vecs.push_back(mk(4'b0000,1'b1,4'b1111,1'b0, 1'b1,1'b0,4'b0000,4'b0100,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b1,4'b0100,4'b0100,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b1,1'b1,4'b0100,4'b0100,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    // collision: re-rise of bit 0 lands on its clear edge
    vecs.push_back(mk(4'b0001,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0001,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b1,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0001,1'b0,4'b0000,1'b1, 1'b1,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0001,1'b0,4'b0000,1'b1, 1'b1,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b1,1'b1,4'b0001,4'b0001,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    // bring the controller into ACK with pending=0110 ahead of the reset abort
    vecs.push_back(mk(4'b0110,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0110,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0000,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b0,4'b0000,4'b0110,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b1,1'b1,4'b0110,4'b0110,4'b1111));
    vecs.push_back(mk(4'b0000,1'b0,4'b0000,1'b1, 1'b1,1'b1,4'b0100,4'b0110,4'b1111));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset in the middle of ACK: outputs clear without a clock edge.
    rst_n = 1'b0;
    #1;
    expect_out("rst_async_clear", 14'd0);
    check_out();
    bus.int_ack = 1'b0;
    bus.irq_in  = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_vec(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b0000), "post_rst_idle");
    run_vec(mk(4'b0000,1'b1,4'b1111,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111), "post_rst_mask");
    run_vec(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111), "post_rst_no_req");
    run_vec(mk(4'b0000,1'b0,4'b0000,1'b0, 1'b0,1'b0,4'b0000,4'b0000,4'b1111), "post_rst_still_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
